// File: rtl/rom_rd_buf.sv
// ============================================================================
// rom_rd_buf : 1-cycle-latency ROM read issue + credit-protected output FIFO
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module rom_rd_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  input  logic              addr_last,
  output logic              addr_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              burst_done,
  output logic [7:0]        burst_cnt
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic              rst_q;
  logic              pending;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              last_mem [DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [PW:0]       inflight;

  // Credit counts the word still in the ROM pipe; a same-cycle pop is not credited.
  assign inflight   = count + {{PW{1'b0}}, pending};
  assign addr_ready = !rst_q && (inflight < FULL);
  assign accept     = addr_valid && addr_ready;

  assign mem_en     = accept;
  assign mem_addr   = accept ? addr_in : addr_q;

  assign push       = pending;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = data_mem[rd_ptr];
  assign out_last   = last_mem[rd_ptr];

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pending    <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      burst_done <= 1'b0;
      burst_cnt  <= 8'd0;
    end else begin
      pending <= accept;
      if (accept) begin
        last_q <= addr_last;
        addr_q <= addr_in;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      burst_done <= pop && out_last;
      if (pop && out_last) burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // A read issued just before reset lands during reset and is dropped here.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem[wr_ptr] <= mem_rdata;
      last_mem[wr_ptr] <= last_q;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));

endmodule

`default_nettype wire

// File: tb/tb_rom_rd_buf.sv
// ============================================================================
// tb_rom_rd_buf : randomized self-checking bench with a queue-based model
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rom_rd_buf;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr_in = '0;
  logic              addr_valid = 1'b0;
  logic              addr_last = 1'b0;
  logic              addr_ready;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              burst_done;
  logic [7:0]        burst_cnt;

  rom_rd_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .addr_in(addr_in), .addr_valid(addr_valid), .addr_last(addr_last), .addr_ready(addr_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .burst_done(burst_done), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    return {8'h00, a} + 16'h0100;
  endfunction

  // ROM: one-cycle latency; garbage on idle cycles so stray writes show up.
  always @(posedge clk) mem_rdata <= mem_en ? rom(mem_addr) : DATA_W'($urandom);

  typedef struct { logic [DATA_W-1:0] d; logic l; } ent_t;
  typedef struct { logic [ADDR_W-1:0] a; logic l; } tx_t;

  ent_t mq[$];
  tx_t  tx_q[$];
  int   acc_cyc[$];
  int   pop_cyc[$];
  bit   prev_acc = 1'b0;
  bit   prev_pl = 1'b0;
  bit   rst_prev = 1'b1;
  bit   last_known = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0] exp_cnt = 8'd0;
  int   issued = 0;
  int   pulses = 0;

  // Model: every accepted, not-yet-popped word is either in the ROM pipe or the FIFO.
  always @(negedge clk) begin
    bit exp_ready, exp_valid, acc, pop;
    if (rst) begin
      mq.delete();
      prev_acc   = 1'b0;
      prev_pl    = 1'b0;
      exp_cnt    = 8'd0;
      last_known = 1'b0;
      rst_prev   = 1'b1;
    end else begin
      exp_ready = !rst_prev && (mq.size() < DEPTH);
      exp_valid = (mq.size() - (prev_acc ? 1 : 0)) > 0;
      check("addr_ready", 32'(addr_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("burst_done", 32'(burst_done), 32'(prev_pl));
      check("burst_cnt", 32'(burst_cnt), 32'(exp_cnt));
      acc = addr_valid && exp_ready;
      check("mem_en", 32'(mem_en), 32'(acc));
      if (acc) check("mem_addr", 32'(mem_addr), 32'(addr_in));
      else if (last_known) check("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
      if (exp_valid) begin
        check("out_data", 32'(out_data), 32'(mq[0].d));
        check("out_last", 32'(out_last), 32'(mq[0].l));
      end
      pop = exp_valid && out_ready;
      prev_pl = pop && mq[0].l;
      if (prev_pl) exp_cnt = exp_cnt + 8'd1;
      if (pop) begin
        void'(mq.pop_front());
        pop_cyc.push_back(cyc);
      end
      if (acc) begin
        mq.push_back('{d: rom(addr_in), l: addr_last});
        last_addr  = addr_in;
        last_known = 1'b1;
        acc_cyc.push_back(cyc);
      end
      prev_acc = acc;
      rst_prev = 1'b0;
      if (mem_en) issued++;
      if (burst_done) pulses++;
    end
  end

  task automatic run_tx(input int vpct, input int rpct, input int maxcyc);
    int n = 0;
    while (tx_q.size() > 0 && n < maxcyc) begin
      @(posedge clk); #1;
      addr_valid = ($urandom_range(99) < vpct);
      addr_in    = addr_valid ? tx_q[0].a : ADDR_W'($urandom);
      addr_last  = addr_valid ? tx_q[0].l : 1'($urandom);
      out_ready  = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (addr_valid && addr_ready) void'(tx_q.pop_front());
      n++;
    end
  endtask

  task automatic drain(input int maxcyc);
    int n = 0;
    @(posedge clk); #1;
    addr_valid = 1'b0;
    addr_last  = 1'b0;
    out_ready  = 1'b1;
    while ((mq.size() > 0 || prev_acc) && n < maxcyc) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_left", 32'(mq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; addr_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
    $fatal(1);
  end

  initial begin
    int nb, left, len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset while a read is in flight.
    addr_valid = 1'b1; addr_in = 8'h10; addr_last = 1'b1;
    @(posedge clk); #1;
    addr_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready_hold", 32'(addr_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    @(negedge clk);
    check("rst_ready_back", 32'(addr_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_no_store", 32'(out_valid), 32'd0);

    // Single streaming burst.
    acc_cyc.delete(); pop_cyc.delete(); pulses = 0;
    for (int i = 0; i < 8; i++) tx_q.push_back('{a: ADDR_W'(i), l: (i == 7)});
    run_tx(100, 100, 40);
    check("stream_tx_left", 32'(tx_q.size()), 32'd0);
    drain(40);
    check("stream_acc_n", 32'(acc_cyc.size()), 32'd8);
    check("stream_pop_n", 32'(pop_cyc.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < pop_cyc.size() && acc_cyc.size() > 0)
        check("stream_timing", 32'(pop_cyc[i]), 32'(acc_cyc[0] + 2 + i));
    check("stream_pulses", 32'(pulses), 32'd1);
    check("stream_cnt", 32'(burst_cnt), 32'd1);

    // Backpressure fill.
    issued = 0;
    for (int i = 0; i < 10; i++) tx_q.push_back('{a: ADDR_W'(8'h20 + i), l: (i == 9)});
    run_tx(100, 0, 12);
    #1;
    check("bp_tx_left", 32'(tx_q.size()), 32'd6);
    check("bp_issued", 32'(issued), 32'd4);
    check("bp_ready", 32'(addr_ready), 32'd0);
    check("bp_mem_en", 32'(mem_en), 32'd0);
    run_tx(100, 100, 100);
    check("bp_tx_done", 32'(tx_q.size()), 32'd0);
    drain(40);
    check("bp_issued_all", 32'(issued), 32'd10);

    // Push and pop together at DEPTH-1, across the pointer wrap.
    for (int i = 0; i < 4; i++) tx_q.push_back('{a: ADDR_W'(8'h40 + i), l: 1'b0});
    run_tx(100, 0, 20);
    check("wrap_fill", 32'(tx_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) tx_q.push_back('{a: ADDR_W'(8'h50 + i), l: (i == 7)});
    run_tx(100, 100, 100);
    check("wrap_tx_done", 32'(tx_q.size()), 32'd0);
    drain(40);

    // Random stalls, 200 addresses in bursts of 1..8.
    do_reset();
    pulses = 0; nb = 0; left = 200;
    while (left > 0) begin
      len = $urandom_range(8, 1);
      if (len > left) len = left;
      for (int i = 0; i < len; i++) tx_q.push_back('{a: ADDR_W'($urandom), l: (i == len - 1)});
      left -= len;
      nb++;
    end
    run_tx(50, 50, 6000);
    check("rand_tx_done", 32'(tx_q.size()), 32'd0);
    drain(200);
    check("rand_burst_cnt", 32'(burst_cnt), 32'(nb % 256));
    check("rand_pulses", 32'(pulses), 32'(nb));

    // burst_cnt wrap with 256 single-word bursts.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 256; i++) tx_q.push_back('{a: ADDR_W'(i), l: 1'b1});
    run_tx(100, 100, 3000);
    check("cwrap_tx_done", 32'(tx_q.size()), 32'd0);
    drain(100);
    check("cwrap_pulses", 32'(pulses), 32'd256);
    check("cwrap_cnt", 32'(burst_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
